dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Parametrised successor to the single-cycle 16-bit data memory: byte-addressed data RAM with byte/half/word load-store modes, sign/zero extension, alignment checking and a registered read path.
- Adds a valid/ready request handshake and a post-reset clear sweep, so every load after init_done returns a defined value.
- Sits in the MEM stage of the pipelined CPU.

Parameters:
- DATA_W, 32: word width in bits; legal values 16 or 32.
- ADDR_W, 12: byte-address width; DEPTH = 2^(ADDR_W - OFS_W) words, where OFS_W = log2(DATA_W/8).
- INIT_CLEAR, 1: 1 = zero the whole array after reset; 0 = skip the sweep, contents undefined.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- rsp_valid  out  1  response pulse.
- rsp_rdata  out  DATA_W  load result, extended to DATA_W.
- rsp_err  out  1  misaligned or illegal request.
- init_done  out  1  clear sweep finished.

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, init_done=0.
  - Sweep counter=0.
  - FSM goes to INIT if INIT_CLEAR=1, else RUN.
- FSM states INIT, RUN:
  - INIT: one word per cycle, address = counter, data = 0, all lanes enabled.
  - INIT exits to RUN on the edge that writes word DEPTH-1.
  - In RUN: init_done=1 and req_ready=1; both stay 0 throughout INIT.
  - INIT lasts exactly DEPTH cycles after the first posedge with rst_n=1.
  - If INIT_CLEAR=0: RUN and req_ready=1 from the first posedge after reset release.
- Handshake and timing:
  - A request is accepted when req_valid && req_ready.
  - No response back-pressure.
  - rsp_valid is high for exactly one cycle, on the cycle after acceptance, for both loads and stores.
  - Full throughput: one request per cycle.
- Addressing:
  - Little-endian; byte offset off = req_addr[OFS_W-1:0]; word index = req_addr >> OFS_W.
  - Offset 0 maps to bits [7:0].
- Error conditions (no array write; rsp_rdata=0, rsp_err=1):
  - size=01 and addr[0]=1.
  - size=10 and off!=0.
  - size=11.
  - size=10 when DATA_W=16.
- Stores (writes on the acceptance edge; rsp_rdata=0, rsp_err=0):
  - byte: lane off ← wdata[7:0].
  - half: lanes off, off+1 ← wdata[15:0].
  - word: all lanes ← wdata.
  - All other lanes are untouched.
- Loads:
  - Synchronous array read at the acceptance edge.
  - Lane selection and extension are done on the registered word.
  - byte result: {ext(b[7]), b}; half result: {ext(h[15]), h}; word: raw.
  - req_signed is ignored for word loads.
- Ordering: a store accepted in cycle N followed by a load to the same word in cycle N+1 returns the new data, because the write completes before the read edge.
- Hazards and reset:
  - Data presented while req_ready=0 is ignored.
  - Reset asserted mid-INIT restarts the sweep at 0.
  - Reset asserted mid-operation drops the pending response (rsp_valid=0).
  - A store accepted in the cycle reset asserts is not guaranteed.

Decomposition:
- Shared package dmem_pkg holds:
  - Size encodings SZ_B, SZ_H, SZ_W, SZ_BAD.
  - Function lane_mask(size, off), returning the byte-enable vector.
  - Function load_extend(word, size, off, signed).
- One sub-module, dmem_byte_ram:
  - DEPTH x DATA_W array.
  - Per-byte write enable.
  - Registered read port.
  - No reset on the array.

Test Plan:
- INIT timing: ADDR_W=6, DATA_W=32 (DEPTH=16); release reset → init_done and req_ready rise exactly 16 cycles after the first posedge; lw 0x3C → rdata 0x00000000.
- Word round trip: sw 0xDEADBEEF @0x10, then lw @0x10 in the next cycle → rsp_valid in both following cycles; second rdata = 0xDEADBEEF, err=0.
- Byte extension: sb 0x80 @0x13 over 0x00000000; lb @0x13 → 0xFFFFFF80; lbu @0x13 → 0x00000080; lw @0x10 → 0x80000000.
- Half lanes and misalignment:
  - sh 0x1234 @0x22 → lw @0x20 = 0x12340000.
  - sh @0x21 → rsp_err=1, rdata=0.
  - A following lw @0x20 is still 0x12340000.
  - size=11 → err=1.
- Reset mid-operation:
  - Assert rst_n=0 at INIT count 5 → after release the sweep restarts and takes a full DEPTH cycles.
  - Assert reset the cycle after a load is accepted → rsp_valid stays 0.
- DATA_W=16 build:
  - lw → err=1.
  - sh 0xA5C3 @0x4, lb @0x5 signed → 0xFFA5.
  - lbu @0x4 → 0x00C3.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_lsu shared types and lane helpers.
// Byte-lane masks and load extension for the MEM stage.
package dmem_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_BAD = 2'b11;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  // Byte enables for up to four lanes; narrower words use the low bits.
  function automatic logic [3:0] lane_mask(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      size == SZ_B: m = 4'b0001 << off;
      size == SZ_H: m = 4'b0011 << off;
      size == SZ_W: m = 4'b1111;
      default:      m = 4'b0000;
    endcase
    return m;
  endfunction

  // Pick the addressed lane(s) and extend to 32 bits.
  function automatic logic [31:0] load_extend(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  off,
    input logic        sgn
  );
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    r  = word;
    unique case (1'b1)
      size == SZ_B: r = {{24{sgn & sh[7]}}, sh[7:0]};
      size == SZ_H: r = {{16{sgn & sh[15]}}, sh[15:0]};
      default:      r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// dmem_lsu storage array.
// Per-byte write enables, registered read, no reset.
module dmem_byte_ram #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 10
) (
  input  logic                clk,
  input  logic [DATA_W/8-1:0] be,
  input  logic [IDX_W-1:0]    addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**IDX_W];

  // Masked byte write and synchronous read of the same index.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage data RAM with byte/half/word access.
// Clears itself after reset, then serves one request per cycle.
import dmem_pkg::*;

module dmem_lsu #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 12,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int NB    = DATA_W / 8;
  localparam int OFS_W = $clog2(NB);
  localparam int IDX_W = ADDR_W - OFS_W;
  localparam int DEPTH = 2**IDX_W;

  state_t            state;
  state_t            state_nx;
  logic [IDX_W-1:0]  cnt;
  logic              live;
  logic [1:0]        off2;
  logic              bad;
  logic              acc;
  logic [3:0]        mask4;
  logic [NB-1:0]     be;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rep;
  logic              vld_q;
  logic              err_q;
  logic              ld_q;
  logic [1:0]        ld_size;
  logic [1:0]        ld_off;
  logic              ld_sgn;
  logic [31:0]       ext;

  assign off2      = 2'(req_addr[OFS_W-1:0]);
  assign req_ready = (state == ST_RUN) && live;
  assign init_done = req_ready;
  assign acc       = req_valid && req_ready;
  assign mask4     = lane_mask(req_size, off2);

  // Misaligned or unsupported request.
  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      req_size == SZ_BAD: bad = 1'b1;
      req_size == SZ_W:   bad = (DATA_W == 16) || (off2 != 2'b00);
      req_size == SZ_H:   bad = req_addr[0];
      default:            bad = 1'b0;
    endcase
  end

  // Replicate store data so every lane sees its bytes.
  always_comb begin
    rep = req_wdata;
    unique case (1'b1)
      req_size == SZ_B: rep = {NB{req_wdata[7:0]}};
      req_size == SZ_H: rep = {(NB/2){req_wdata[15:0]}};
      default:          rep = req_wdata;
    endcase
  end

  // RAM port: sweep writes during INIT, requests afterwards.
  always_comb begin
    be        = '0;
    ram_addr  = req_addr[ADDR_W-1:OFS_W];
    ram_wdata = rep;
    if (state == ST_INIT) begin
      be        = '1;
      ram_addr  = cnt;
      ram_wdata = '0;
    end else if (acc && req_we && !bad) begin
      be = mask4[NB-1:0];
    end
  end

  // Leave INIT on the edge that writes the last word.
  always_comb begin
    state_nx = state;
    if (state == ST_INIT && cnt == IDX_W'(DEPTH - 1)) state_nx = ST_RUN;
  end

  // State, sweep counter and post-reset qualifier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
      cnt   <= '0;
      live  <= 1'b0;
    end else begin
      state <= state_nx;
      live  <= 1'b1;
      if (state == ST_INIT) cnt <= cnt + IDX_W'(1);
    end
  end

  // Capture the accepted request for the response cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
      ld_size <= SZ_B;
      ld_off  <= 2'b00;
      ld_sgn  <= 1'b0;
    end else begin
      vld_q <= acc;
      if (acc) begin
        err_q   <= bad;
        ld_q    <= !req_we && !bad;
        ld_size <= req_size;
        ld_off  <= off2;
        ld_sgn  <= req_signed;
      end
    end
  end

  assign ext       = load_extend(32'(ram_rdata), ld_size, ld_off, ld_sgn);
  assign rsp_valid = vld_q;
  assign rsp_err   = vld_q && err_q;
  assign rsp_rdata = (vld_q && ld_q) ? ext[DATA_W-1:0] : '0;

  dmem_byte_ram #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .be    (be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: a 32-bit and a 16-bit instance
// against a byte-array model, plus literal spot checks.
module tb_dmem_lsu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       v;
  logic [1:0]       we;
  logic [1:0]       sg;
  logic [1:0][1:0]  sz;
  logic [1:0][5:0]  ad;
  logic [1:0][31:0] wd;
  logic [1:0]       rdy;
  logic [1:0]       rv;
  logic [1:0]       er;
  logic [1:0]       idn;
  logic [31:0]      rd0;
  logic [15:0]      rd1;

  int checks = 0;
  int failures = 0;

  dmem_lsu #(.DATA_W(32), .ADDR_W(6), .INIT_CLEAR(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v[0]), .req_ready(rdy[0]), .req_we(we[0]),
    .req_size(sz[0]), .req_signed(sg[0]), .req_addr(ad[0]),
    .req_wdata(wd[0]),
    .rsp_valid(rv[0]), .rsp_rdata(rd0), .rsp_err(er[0]),
    .init_done(idn[0])
  );

  dmem_lsu #(.DATA_W(16), .ADDR_W(6), .INIT_CLEAR(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v[1]), .req_ready(rdy[1]), .req_we(we[1]),
    .req_size(sz[1]), .req_signed(sg[1]), .req_addr(ad[1]),
    .req_wdata(wd[1][15:0]),
    .rsp_valid(rv[1]), .rsp_rdata(rd1), .rsp_err(er[1]),
    .init_done(idn[1])
  );

  // Model: byte-addressed memory, cycles since reset, pending response.
  logic [7:0]  mem [2][64];
  int          cnt [2];
  logic [1:0]  ev;
  logic [1:0]  ee;
  logic [31:0] erd [2];

  function automatic int nb_f(int d);
    return (d == 1) ? 2 : 4;
  endfunction

  function automatic int dep_f(int d);
    return 64 / nb_f(d);
  endfunction

  function automatic int bytes_f(int d, logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : nb_f(d);
  endfunction

  function automatic logic bad_f(int d, logic [1:0] s, logic [5:0] a);
    int n;
    n = nb_f(d);
    return (s == 2'd3) || (s == 2'd1 && a[0]) ||
           (s == 2'd2 && (n == 2 || (int'(a) % n) != 0));
  endfunction

  function automatic logic [31:0] load_f(int d, logic [1:0] s,
                                         logic g, logic [5:0] a);
    logic [31:0] r;
    int ai;
    ai = int'(a);
    if (s == 2'd0) begin
      r = {24'h0, mem[d][ai]};
      if (g && mem[d][ai][7]) r = r | 32'hFFFF_FF00;
    end else if (s == 2'd1) begin
      r = {16'h0, mem[d][ai+1], mem[d][ai]};
      if (g && mem[d][ai+1][7]) r = r | 32'hFFFF_0000;
    end else begin
      r = {mem[d][ai+3], mem[d][ai+2], mem[d][ai+1], mem[d][ai]};
    end
    if (nb_f(d) == 2) r = r & 32'h0000_FFFF;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        cnt[d] <= 0;
        ev[d]  <= 1'b0;
        ee[d]  <= 1'b0;
        erd[d] <= 32'h0;
        for (int i = 0; i < 64; i++) mem[d][i] <= 8'h00;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (cnt[d] < dep_f(d)) cnt[d] <= cnt[d] + 1;
        ev[d] <= v[d] && (cnt[d] == dep_f(d));
        if (v[d] && cnt[d] == dep_f(d)) begin
          ee[d]  <= bad_f(d, sz[d], ad[d]);
          erd[d] <= 32'h0;
          if (!bad_f(d, sz[d], ad[d])) begin
            if (we[d]) begin
              for (int k = 0; k < bytes_f(d, sz[d]); k++)
                mem[d][int'(ad[d]) + k] <= wd[d][8*k +: 8];
            end else begin
              erd[d] <= load_f(d, sz[d], sg[d], ad[d]);
            end
          end
        end
      end
    end
  end

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endfunction

  // Every cycle: both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("ready%0d", d), 32'(rdy[d]), 32'(cnt[d] == dep_f(d)));
      chk($sformatf("init_done%0d", d), 32'(idn[d]), 32'(cnt[d] == dep_f(d)));
      chk($sformatf("rsp_valid%0d", d), 32'(rv[d]), 32'(ev[d]));
      if (ev[d]) begin
        chk($sformatf("rsp_err%0d", d), 32'(er[d]), 32'(ee[d]));
        chk($sformatf("rsp_rdata%0d", d),
            (d == 0) ? rd0 : {16'h0, rd1}, erd[d]);
      end
    end
  end

  task automatic put(int d, logic w, logic [1:0] s, logic g,
                     logic [5:0] a, logic [31:0] dat);
    v[d]  = 1'b1;
    we[d] = w;
    sz[d] = s;
    sg[d] = g;
    ad[d] = a;
    wd[d] = dat;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    v = '0;
  endtask

  initial begin
    v = '0; we = '0; sg = '0; sz = '0; ad = '0; wd = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    // Reset again five cycles into the sweep.
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("init15_ready", 32'(rdy[0]), 32'd0);
    chk("init15_done", 32'(idn[0]), 32'd0);
    step();
    chk("init16_ready", 32'(rdy[0]), 32'd1);
    chk("init16_done", 32'(idn[0]), 32'd1);
    repeat (15) @(negedge clk);
    chk("init31_ready16", 32'(rdy[1]), 32'd0);
    step();
    chk("init32_ready16", 32'(rdy[1]), 32'd1);

    put(0, 0, 2'd2, 0, 6'h3C, 0); step(); idle();
    chk("lw3c_valid", 32'(rv[0]), 32'd1);
    chk("lw3c_data", rd0, 32'h0);

    put(0, 1, 2'd2, 0, 6'h10, 32'hDEADBEEF); step();
    chk("sw_valid", 32'(rv[0]), 32'd1);
    put(0, 0, 2'd2, 0, 6'h10, 0); step(); idle();
    chk("lw_valid", 32'(rv[0]), 32'd1);
    chk("lw_data", rd0, 32'hDEADBEEF);
    chk("lw_err", 32'(er[0]), 32'd0);

    put(0, 1, 2'd2, 0, 6'h10, 32'h0); step();
    put(0, 1, 2'd0, 0, 6'h13, 32'h80); step();
    put(0, 0, 2'd0, 1, 6'h13, 0); step();
    chk("lb_data", rd0, 32'hFFFFFF80);
    put(0, 0, 2'd0, 0, 6'h13, 0); step();
    chk("lbu_data", rd0, 32'h00000080);
    put(0, 0, 2'd2, 0, 6'h10, 0); step(); idle();
    chk("lw_after_sb", rd0, 32'h80000000);

    put(0, 1, 2'd1, 0, 6'h22, 32'h1234); step();
    put(0, 0, 2'd2, 0, 6'h20, 0); step();
    chk("lw_after_sh", rd0, 32'h12340000);
    put(0, 1, 2'd1, 0, 6'h21, 32'h5555); step();
    chk("sh_mis_err", 32'(er[0]), 32'd1);
    chk("sh_mis_data", rd0, 32'h0);
    put(0, 0, 2'd2, 0, 6'h20, 0); step();
    chk("lw_after_mis", rd0, 32'h12340000);
    put(0, 0, 2'd3, 0, 6'h00, 0); step(); idle();
    chk("size11_err", 32'(er[0]), 32'd1);

    put(1, 0, 2'd2, 0, 6'h00, 0); step(); idle();
    chk("w16_lw_err", 32'(er[1]), 32'd1);
    put(1, 1, 2'd1, 0, 6'h04, 32'hA5C3); step();
    put(1, 0, 2'd0, 1, 6'h05, 0); step();
    chk("w16_lb", {16'h0, rd1}, 32'h0000FFA5);
    put(1, 0, 2'd0, 0, 6'h04, 0); step(); idle();
    chk("w16_lbu", {16'h0, rd1}, 32'h000000C3);

    repeat (3000) begin
      for (int d = 0; d < 2; d++) begin
        v[d]  = 1'($urandom_range(0, 1));
        we[d] = 1'($urandom_range(0, 1));
        sz[d] = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        sg[d] = 1'($urandom_range(0, 1));
        ad[d] = 6'($urandom_range(0, 63));
        wd[d] = $urandom;
      end
      step();
    end
    idle();
    step();

    // Reset during the response cycle of a load.
    put(0, 0, 2'd2, 0, 6'h10, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_drop_valid", 32'(rv[0]), 32'd0);
    chk("rst_drop_ready", 32'(rdy[0]), 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
